// File: rtl/cntr_multi_wb.sv
// cntr_multi_wb: NCH Wishbone-programmed up/down wrap/saturate counters on user IO; PRESC divider only with CNTR_PRESCALE_EN
module cntr_multi_wb #(
    parameter int NCH = 4,
    parameter int WIDTH = 16,
    parameter int OUT_BITS = 16,
    parameter logic [31:0] ADDR_BASE = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    input  logic [37:0] io_in,
    output logic [37:0] io_out,
    output logic [37:0] io_oeb,
    output logic [2:0]  user_irq
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    logic [4:0] ctrl [NCH];
    logic [WIDTH-1:0] count [NCH];
    logic [WIDTH-1:0] limit [NCH];
    logic [WIDTH-1:0] nxt [NCH];
    logic [NCH-1:0] tc, s1, s2, s3, tick, wrap, wr, irqen;
    logic [31:0] wm, rdata;
    logic [15:0] presc_rd;
    logic [1:0] rs;
    logic itick, acc, glob, irq_q, unused_bits;
    assign acc = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & (wbs_adr_i[31:8] == ADDR_BASE[31:8]);
    assign glob = wbs_adr_i[7:2] == 6'h3F;
    assign rs = wbs_adr_i[3:2];
    assign wm = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign io_oeb = ~((38'd1 << (OUT_BITS + NCH)) - 38'd1);
    assign user_irq = {2'b00, irq_q};
    assign unused_bits = ^{wbs_adr_i[1:0], io_in};

    function automatic logic [31:0] merge(input logic [31:0] o);
        return (o & ~wm) | (wbs_dat_i & wm);
    endfunction

`ifdef CNTR_PRESCALE_EN
    logic [15:0] presc, div;
    logic presc_wr;
    assign presc_wr = acc & wbs_we_i & glob;
    assign itick = div == presc;
    assign presc_rd = presc;
    // Writing PRESC restarts the spacing so the new period applies from a clean start.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            presc <= '0;
            div <= '0;
        end else begin
            div <= (presc_wr | itick) ? 16'd0 : div + 16'd1;
            if (presc_wr) presc <= 16'(merge(32'(presc)));
        end
    end
`else
    assign itick = 1'b1;
    assign presc_rd = '0;
`endif

    always_comb begin
        wr = '0;
        tick = '0;
        wrap = '0;
        irqen = '0;
        rdata = glob ? 32'(presc_rd) : 32'd0;
        for (int c = 0; c < NCH; c++) begin
            wr[c] = acc & wbs_we_i & (wbs_adr_i[7:4] == 4'(c));
            tick[c] = ctrl[c][0] & (ctrl[c][3] ? s2[c] & ~s3[c] : itick);
            wrap[c] = ctrl[c][1] ? count[c] == '0 : count[c] >= limit[c];
            irqen[c] = ctrl[c][4];
            nxt[c] = wrap[c] ? (ctrl[c][2] ? count[c] : ctrl[c][1] ? limit[c] : '0)
                             : ctrl[c][1] ? count[c] - ONE : count[c] + ONE;
            if (wbs_adr_i[7:4] == 4'(c))
                rdata = rs == 2'd0 ? 32'(ctrl[c]) : rs == 2'd1 ? 32'(count[c]) :
                        rs == 2'd2 ? 32'(limit[c]) : 32'(tc[c]);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            io_out <= '0;
            irq_q <= 1'b0;
            tc <= '0;
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
            for (int c = 0; c < NCH; c++) begin
                ctrl[c] <= '0;
                count[c] <= '0;
                limit[c] <= '1;
            end
        end else begin
            wbs_ack_o <= acc;
            wbs_dat_o <= (acc & ~wbs_we_i) ? rdata : 32'd0;
            io_out <= (38'(tc) << OUT_BITS) | 38'(count[0][OUT_BITS-1:0]);
            irq_q <= |(tc & irqen);
            s1 <= io_in[30 +: NCH];
            s2 <= s1;
            s3 <= s2;
            for (int c = 0; c < NCH; c++) begin
                if (wr[c] && rs == 2'd0) ctrl[c] <= 5'(merge(32'(ctrl[c])));
                if (wr[c] && rs == 2'd2) limit[c] <= WIDTH'(merge(32'(limit[c])));
                if (wr[c] && rs == 2'd3 && wbs_sel_i[0] && wbs_dat_i[0]) tc[c] <= 1'b0;
                // A COUNT load overrides the step, including its TC.
                if (wr[c] && rs == 2'd1) count[c] <= WIDTH'(merge(32'(count[c])));
                else if (tick[c]) begin
                    count[c] <= nxt[c];
                    if (wrap[c]) tc[c] <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_cntr_multi_wb.sv
// tb_cntr_multi_wb: directed checks of cntr_multi_wb registers, counting modes, ticks and handshake
module tb_cntr_multi_wb;
    localparam logic [31:0] B = 32'h3000_0000;
    logic clk = 1'b0, rst = 1'b1;
    logic cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0] sel = 4'hF;
    logic [31:0] adr = '0, dat = '0;
    logic [31:0] dat_o;
    logic ack;
    logic [37:0] io_in = '0;
    logic [37:0] io_out, io_oeb;
    logic [2:0] irq;
    int checks = 0, failures = 0;
    logic [63:0] run_exp [6] = '{64'h0, 64'h1, 64'h2, 64'h3, 64'h10000, 64'h10001};

    cntr_multi_wb dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_dat_o(dat_o), .wbs_ack_o(ack),
        .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .user_irq(irq)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat = d; sel = s;
        step(1);
        chk("wr_ack", 64'(ack), 64'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        step(1);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
        step(1);
        chk({tag, "_ack"}, 64'(ack), 64'd1);
        chk(tag, 64'(dat_o), 64'(exp));
        cyc = 1'b0; stb = 1'b0;
        step(1);
    endtask

    initial begin
        int acks;
        logic [31:0] dor;
        step(3);
        chk("rst_io_out", 64'(io_out), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_dat_o", 64'(dat_o), 64'd0);
        chk("rst_oeb", 64'(io_oeb), 64'h3F_FFF0_0000);
        rst = 1'b0;
        rd(B + 32'h00, 32'h0, "rst_ctrl");
        rd(B + 32'h04, 32'h0, "rst_count");
        rd(B + 32'h08, 32'h0000_FFFF, "rst_limit");
        rd(B + 32'h0C, 32'h0, "rst_status");
        rd(B + 32'h38, 32'h0000_FFFF, "rst_limit3");
        rd(B + 32'hFC, 32'h0, "rst_presc");

        // Held request: acks can come at most every other cycle
        cyc = 1'b1; stb = 1'b1; adr = B + 32'h08; acks = 0;
        repeat (4) begin
            step(1);
            acks += int'(ack);
        end
        chk("ack_spacing", 64'(acks), 64'd2);
        adr = B + 32'h100; acks = 0; dor = '0;
        step(1);
        repeat (3) begin
            step(1);
            acks += int'(ack);
            dor |= dat_o;
        end
        chk("outside_ack", 64'(acks), 64'd0);
        chk("outside_dat", 64'(dor), 64'd0);
        cyc = 1'b0; stb = 1'b0;
        step(1);
        rd(B + 32'h40, 32'h0, "unmapped_rd");
        wr(B + 32'h40, 32'hFFFF_FFFF);

        // ch0 up/wrap at LIMIT=3, watched through io_out
        wr(B + 32'h08, 32'd3);
        wr(B + 32'h00, 32'd1);
        for (int i = 0; i < 6; i++) begin
            if (i != 0) step(1);
            chk("ch0_io_run", 64'(io_out), run_exp[i]);
        end
        wr(B + 32'h00, 32'd0);
        rd(B + 32'h04, 32'd3, "ch0_count_stop");
        rd(B + 32'h0C, 32'd1, "ch0_tc");
        wr(B + 32'h0C, 32'd1);
        rd(B + 32'h0C, 32'd0, "ch0_tc_clr");

        // ch1 down, saturate, irq
        wr(B + 32'h18, 32'd5);
        wr(B + 32'h14, 32'd2);
        wr(B + 32'h10, 32'h17);
        step(4);
        chk("ch1_irq_set", 64'(irq), 64'd1);
        rd(B + 32'h14, 32'd0, "ch1_sat_hold");
        rd(B + 32'h1C, 32'd1, "ch1_tc");
        wr(B + 32'h1C, 32'd1);
        rd(B + 32'h1C, 32'd1, "ch1_set_beats_w1c");
        wr(B + 32'h10, 32'h16);
        wr(B + 32'h1C, 32'd1);
        chk("ch1_irq_clr", 64'(irq), 64'd0);
        rd(B + 32'h1C, 32'd0, "ch1_tc_clr");

        // Byte lanes: only the low byte of LIMIT changes
        wr(B + 32'h28, 32'hABCD_1234, 4'b0001);
        rd(B + 32'h28, 32'h0000_FF34, "ch2_limit_bytelane");

        // ch2 external steps with 3-cycle latency
        wr(B + 32'h20, 32'h9);
        io_in[32] = 1'b1;
        step(2);
        rd(B + 32'h24, 32'd0, "ext_p1_early");
        rd(B + 32'h24, 32'd1, "ext_p1_after");
        io_in[32] = 1'b0;
        step(3);
        io_in[32] = 1'b1;
        step(1);
        rd(B + 32'h24, 32'd1, "ext_p2_before");
        rd(B + 32'h24, 32'd2, "ext_p2_on_time");
        io_in[32] = 1'b0;
        step(3);
        io_in[32] = 1'b1;
        step(4);
        io_in[32] = 1'b0;
        step(3);
        rd(B + 32'h24, 32'd3, "ext_count3");

        // ch3: COUNT write coinciding with a wrapping external tick
        wr(B + 32'h38, 32'd3);
        wr(B + 32'h34, 32'd3);
        wr(B + 32'h30, 32'h9);
        io_in[33] = 1'b1;
        step(2);
        wr(B + 32'h34, 32'd7);
        rd(B + 32'h34, 32'd7, "cnt_wr_wins");
        rd(B + 32'h3C, 32'd0, "cnt_wr_no_tc");
        io_in[33] = 1'b0;
        step(3);
        io_in[33] = 1'b1;
        step(5);
        io_in[33] = 1'b0;
        rd(B + 32'h34, 32'd0, "above_limit_wrap");
        rd(B + 32'h3C, 32'd1, "above_limit_tc");

`ifdef CNTR_PRESCALE_EN
        wr(B + 32'h08, 32'hFFFF);
        wr(B + 32'h04, 32'd0);
        wr(B + 32'hFC, 32'd4);
        wr(B + 32'h00, 32'd1);
        step(2);
        chk("presc_t5", 64'(io_out[15:0]), 64'd0);
        step(1);
        chk("presc_t6", 64'(io_out[15:0]), 64'd1);
        step(4);
        chk("presc_t10", 64'(io_out[15:0]), 64'd1);
        step(1);
        chk("presc_t11", 64'(io_out[15:0]), 64'd2);
        wr(B + 32'hFC, 32'd4);
        step(4);
        chk("presc_restart_hold", 64'(io_out[15:0]), 64'd2);
        step(1);
        chk("presc_restart_step", 64'(io_out[15:0]), 64'd3);
        wr(B + 32'h00, 32'd0);
        rd(B + 32'hFC, 32'd4, "presc_rd");
`else
        wr(B + 32'hFC, 32'd4);
        rd(B + 32'hFC, 32'd0, "presc_absent");
`endif

        // Reset during a pending request drops the ack
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = B + 32'h08; rst = 1'b1;
        step(1);
        chk("rst_mid_ack", 64'(ack), 64'd0);
        chk("rst_mid_io_out", 64'(io_out), 64'd0);
        cyc = 1'b0; stb = 1'b0; rst = 1'b0;
        step(1);
        rd(B + 32'h34, 32'd0, "post_rst_count");
        rd(B + 32'h38, 32'h0000_FFFF, "post_rst_limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
